// File: rtl/mux_scan_nx1.sv
// Registered N:1 channel multiplexer with direct select or masked round-robin scan,
// presenting one sample at a time behind a valid/ready handshake.
module mux_scan_nx1 #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       ch_mask,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_last,
  output logic                      sel_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;
  logic               out_last_q, out_last_d;
  logic               sel_err_q, sel_err_d;

  logic               scan_hit_c;
  logic [SEL_W-1:0]   scan_ch_c;
  logic [SEL_W-1:0]   high_ch_c;
  logic [WIDTH-1:0]   scan_data_c;
  logic [WIDTH-1:0]   dir_data_c;
  logic               sel_ok_c;
  logic               load_c;
  logic [SEL_W:0]     sum_c;
  logic [SEL_W-1:0]   idx_c;

  // First enabled channel at or after ptr (wrapping at CHANNELS) and highest enabled channel.
  always_comb begin
    scan_hit_c = 1'b0;
    scan_ch_c  = '0;
    high_ch_c  = '0;
    sum_c      = '0;
    idx_c      = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sum_c = {1'b0, ptr_q} + (SEL_W+1)'(i);
      if (sum_c >= (SEL_W+1)'(CHANNELS)) sum_c = sum_c - (SEL_W+1)'(CHANNELS);
      idx_c = sum_c[SEL_W-1:0];
      if (!scan_hit_c && ch_mask[idx_c]) begin
        scan_hit_c = 1'b1;
        scan_ch_c  = idx_c;
      end
      if (ch_mask[i]) high_ch_c = SEL_W'(i);
    end
  end

  // Channel data muxes; out-of-range direct select yields zero.
  always_comb begin
    scan_data_c = '0;
    dir_data_c  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (scan_ch_c == SEL_W'(i)) scan_data_c = in_bus[i*WIDTH +: WIDTH];
      if (sel == SEL_W'(i))       dir_data_c  = in_bus[i*WIDTH +: WIDTH];
    end
  end

  assign sel_ok_c = (32'(sel) < 32'(CHANNELS));
  assign load_c   = (state_q == RUN) && en && (!out_valid_q || out_ready) && (!mode || scan_hit_c);

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    sel_err_d   = sel_err_q;

    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = (out_valid_q && !out_ready) ? DRAIN : IDLE;
      DRAIN:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      out_valid_d = 1'b1;
      if (mode) begin
        out_data_d = scan_data_c;
        out_ch_d   = scan_ch_c;
        out_last_d = (scan_ch_c == high_ch_c);
        sel_err_d  = 1'b0;
        ptr_d      = (scan_ch_c == SEL_W'(CHANNELS-1)) ? '0 : scan_ch_c + SEL_W'(1);
      end else begin
        out_data_d = dir_data_c;
        out_ch_d   = sel;
        out_last_d = 1'b0;
        sel_err_d  = !sel_ok_c;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Scoreboard bench for mux_scan_nx1: an 8-channel and a 5-channel instance share stimulus;
// a reference model queues expected samples, a negedge monitor checks every presented sample.
module tb_mux_scan_nx1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_bus;
  logic        en, mode, out_ready;
  logic [2:0]  sel;
  logic [7:0]  ch_mask;

  logic       v0, l0, e0, v1, l1, e1;
  logic [3:0] d0, d1;
  logic [2:0] c0, c1;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] ch;
    logic       last;
    logic       err;
  } smp_t;

  smp_t q0[$];
  smp_t q1[$];
  int   m_phase[2];
  bit   m_valid[2];
  int   m_ptr[2];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_scan_nx1 #(.WIDTH(4), .CHANNELS(8)) dut8 (
    .clk(clk), .rst(rst), .in_bus(in_bus), .en(en), .mode(mode), .sel(sel),
    .ch_mask(ch_mask), .out_ready(out_ready), .out_valid(v0), .out_data(d0),
    .out_ch(c0), .out_last(l0), .sel_err(e0));

  mux_scan_nx1 #(.WIDTH(4), .CHANNELS(5)) dut5 (
    .clk(clk), .rst(rst), .in_bus(in_bus[19:0]), .en(en), .mode(mode), .sel(sel),
    .ch_mask(ch_mask[4:0]), .out_ready(out_ready), .out_valid(v1), .out_data(d1),
    .out_ch(c1), .out_last(l1), .sel_err(e1));

  function automatic logic [3:0] chan_val(input int k);
    return in_bus[k*4 +: 4];
  endfunction

  // Reference model: one step per clock edge for instance d (8 or 5 channels).
  task automatic model_step(input int d);
    int   n, hi, c, t;
    bit   load, hit;
    smp_t s;
    n = (d == 0) ? 8 : 5;
    load = 0;
    s = '0;
    if (rst) begin
      m_phase[d] = 0; m_valid[d] = 0; m_ptr[d] = 0;
      if (d == 0) q0.delete(); else q1.delete();
      return;
    end
    case (m_phase[d])
      0: if (en) m_phase[d] = 1;
      1: begin
        if (!en) begin
          m_phase[d] = (m_valid[d] && !out_ready) ? 2 : 0;
        end else if (!m_valid[d] || out_ready) begin
          if (!mode) begin
            load = 1;
            s.ch = sel;
            if (int'(sel) < n) s.data = chan_val(int'(sel));
            else s.err = 1'b1;
          end else begin
            hit = 0; hi = -1; c = 0;
            for (int k = 0; k < n; k++) if (ch_mask[k]) hi = k;
            for (int k = 0; k < n; k++) begin
              t = (m_ptr[d] + k) % n;
              if (!hit && ch_mask[t]) begin hit = 1; c = t; end
            end
            if (hit) begin
              load = 1;
              s.data = chan_val(c);
              s.ch = 3'(c);
              s.last = (c == hi);
              m_ptr[d] = (c + 1) % n;
            end
          end
        end
      end
      default: if (out_ready) m_phase[d] = 0;
    endcase
    if (load) begin
      m_valid[d] = 1;
      if (d == 0) q0.push_back(s); else q1.push_back(s);
    end else if (m_valid[d] && out_ready) begin
      m_valid[d] = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Monitor: compares valid every cycle and the presented sample against the scoreboard head.
  task automatic mon(input int d, input logic v, input logic [3:0] dt, input logic [2:0] ch,
                     input logic l, input logic e);
    smp_t got, exp;
    int   sz;
    got = {dt, ch, l, e};
    checks++;
    if (v !== m_valid[d]) begin
      errors++;
      $display("FAIL valid[%0d] t=%0t got %b expected %b", d, $time, v, m_valid[d]);
    end
    if (v === 1'b1) begin
      sz = (d == 0) ? q0.size() : q1.size();
      checks++;
      if (sz == 0) begin
        errors++;
        $display("FAIL sample[%0d] t=%0t got data=%h ch=%0d with no expected sample", d, $time, dt, ch);
      end else begin
        exp = (d == 0) ? q0[0] : q1[0];
        if (got !== exp) begin
          errors++;
          $display("FAIL sample[%0d] t=%0t got data=%h ch=%0d last=%b err=%b expected data=%h ch=%0d last=%b err=%b",
                   d, $time, got.data, got.ch, got.last, got.err, exp.data, exp.ch, exp.last, exp.err);
        end
        if (out_ready) begin
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, v0, d0, c0, l0, e0);
    mon(1, v1, d1, c1, l1, e1);
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v0"}, int'(v0), 0);
    chk({tag, "_d0"}, int'(d0), 0);
    chk({tag, "_c0"}, int'(c0), 0);
    chk({tag, "_le0"}, int'({l0, e0}), 0);
    chk({tag, "_all1"}, int'({v1, d1, c1, l1, e1}), 0);
  endtask

  initial begin
    rst = 1; en = 0; mode = 0; sel = 0; ch_mask = 0; out_ready = 0; in_bus = 0;
    tick(2);
    chk_zero("reset");

    // Direct mode, channel k holds k+3
    rst = 0;
    for (int k = 0; k < 8; k++) in_bus[k*4 +: 4] = 4'(k + 3);
    sel = 3'd5; out_ready = 1; en = 1;
    tick(2);
    chk("t1_valid", int'(v0), 1);
    chk("t1_data", int'(d0), 8);
    chk("t1_ch", int'(c0), 5);
    chk("t1_err5", int'(e1), 1);
    tick(4);

    // Scan over mask 1010_0100
    mode = 1; ch_mask = 8'b1010_0100;
    tick(7);

    // Backpressure on a scan sample
    out_ready = 0;
    tick(4);
    out_ready = 1;
    tick(4);

    // Out-of-range select on the 5-channel instance, then wrap at 5
    mode = 0; sel = 3'd6;
    tick(2);
    chk("t4_err", int'(e1), 1);
    chk("t4_data", int'(d1), 0);
    mode = 1; ch_mask = 8'b0001_0001;
    tick(6);

    // Drop en with a pending sample: drain then idle
    out_ready = 0;
    tick(1);
    en = 0;
    tick(3);
    out_ready = 1;
    tick(4);

    // Empty mask, then reset in the middle of a handshake
    en = 1; mode = 1; ch_mask = 8'h00;
    tick(4);
    ch_mask = 8'hFF;
    tick(3);
    out_ready = 0;
    tick(1);
    rst = 1;
    tick(1);
    chk_zero("midrst");
    rst = 0; out_ready = 1;
    tick(5);

    // Randomised phase
    for (int i = 0; i < 600; i++) begin
      in_bus    = $urandom;
      sel       = 3'($urandom_range(0, 7));
      ch_mask   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    rst = 0; en = 0; out_ready = 1;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
